// File: rtl/float_point_mult_arbiter_if.sv
// float_point_mult_arbiter_if
// Bundles the requester bus and the shared-multiplier bus of the
// float_point_mult_arbiter into a single interface.
//
// Signals:
//   inp_req_valid    NUM_REQ    per-requester request
//   inp_req_a        NUM_REQ*W  packed operand A, requester i at [i*W +: W]
//   inp_req_b        NUM_REQ*W  packed operand B, same packing
//   out_req_grant    NUM_REQ    one-hot combinational grant
//   out_mult_a       W          registered operand A to the multiplier
//   out_mult_b       W          registered operand B to the multiplier
//   out_mult_valid   1          registered issue strobe
//   inp_mult_product W          multiplier result
//   out_rsp_valid    NUM_REQ    one-hot one-cycle result strobe
//   out_rsp_product  W          registered product, zero when idle
//   out_busy         1          operation in flight
//
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding requesters / multiplier view
interface float_point_mult_arbiter_if #(
  parameter int W       = 32,
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   inp_req_valid;
  logic [NUM_REQ*W-1:0] inp_req_a;
  logic [NUM_REQ*W-1:0] inp_req_b;
  logic [NUM_REQ-1:0]   out_req_grant;
  logic [W-1:0]         out_mult_a;
  logic [W-1:0]         out_mult_b;
  logic                 out_mult_valid;
  logic [W-1:0]         inp_mult_product;
  logic [NUM_REQ-1:0]   out_rsp_valid;
  logic [W-1:0]         out_rsp_product;
  logic                 out_busy;

  modport slave (
    input  inp_req_valid,
    input  inp_req_a,
    input  inp_req_b,
    input  inp_mult_product,
    output out_req_grant,
    output out_mult_a,
    output out_mult_b,
    output out_mult_valid,
    output out_rsp_valid,
    output out_rsp_product,
    output out_busy
  );

  modport master (
    output inp_req_valid,
    output inp_req_a,
    output inp_req_b,
    output inp_mult_product,
    input  out_req_grant,
    input  out_mult_a,
    input  out_mult_b,
    input  out_mult_valid,
    input  out_rsp_valid,
    input  out_rsp_product,
    input  out_busy
  );

endinterface

// File: rtl/float_point_mult_arbiter.sv
// float_point_mult_arbiter
// Shares one external floating-point multiplier among NUM_REQ requesters
// with round-robin arbitration. Each grant issues one operand pair to the
// multiplier; a tag pipeline matched to the multiplier latency carries the
// requester id so the product is steered back to whoever issued it.
// Products pass through untouched; no FP arithmetic happens here.
//
// Ports:
//   clock    sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      float_point_mult_arbiter_if.slave (requester + multiplier buses)
//
// Parameters:
//   EXP_LEN, MANTISSA_LEN  float format, W = EXP_LEN + MANTISSA_LEN + 1
//   NUM_REQ                number of requesters (2..16)
//   MULT_DELAY             cycles from out_mult_valid to a valid product (>=1)
//   PIPELINED              1: issue every cycle, 0: one operation in flight
module float_point_mult_arbiter #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int NUM_REQ      = 4,
  parameter int MULT_DELAY   = 3,
  parameter int PIPELINED    = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  float_point_mult_arbiter_if.slave bus
);

  localparam int W    = EXP_LEN + MANTISSA_LEN + 1;
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(MULT_DELAY + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] next_count;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  search_idx;
  logic            found;
  logic            grant_allowed;
  logic            grant_fire;

  logic [W-1:0]    req_a_arr [NUM_REQ];
  logic [W-1:0]    req_b_arr [NUM_REQ];

  logic [IDW-1:0]  issue_id;
  logic            tag_valid [MULT_DELAY];
  logic [IDW-1:0]  tag_id    [MULT_DELAY];
  logic            tags_busy;

  // Unpack the flat operand buses so the winner can select by index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_a_arr[g] = bus.inp_req_a[g*W +: W];
    assign req_b_arr[g] = bus.inp_req_b[g*W +: W];
  end

  // Round-robin search: start one past the last winner and wrap, so the
  // requester granted most recently has the lowest priority next time.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    search_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      search_idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && bus.inp_req_valid[search_idx]) begin
        found  = 1'b1;
        winner = search_idx;
      end
    end
  end

  // A non-pipelined multiplier only takes a new operation from IDLE.
  always_comb begin
    grant_allowed     = (PIPELINED != 0) || (state == IDLE);
    grant_fire        = found && grant_allowed;
    bus.out_req_grant = grant_fire ? (NUM_REQ'(1) << winner) : '0;
  end

  // Issue register: operands and id of the winner are captured on the
  // grant edge; the pointer only moves when something is actually granted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_mult_valid <= 1'b0;
      bus.out_mult_a     <= '0;
      bus.out_mult_b     <= '0;
      issue_id           <= '0;
      rr_ptr             <= IDW'(NUM_REQ - 1);
    end else begin
      bus.out_mult_valid <= grant_fire;
      if (grant_fire) begin
        bus.out_mult_a <= req_a_arr[winner];
        bus.out_mult_b <= req_b_arr[winner];
        issue_id       <= winner;
        rr_ptr         <= winner;
      end
    end
  end

  // Tag pipeline follows the issue register, so the last stage lines up
  // with the cycle in which the multiplier's product is valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < MULT_DELAY; k++) begin
        tag_valid[k] <= 1'b0;
        tag_id[k]    <= '0;
      end
    end else begin
      tag_valid[0] <= bus.out_mult_valid;
      tag_id[0]    <= issue_id;
      for (int k = 1; k < MULT_DELAY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  // Response register: steer the product back to its requester, and
  // force the product bus to zero on cycles without a response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_rsp_valid   <= '0;
      bus.out_rsp_product <= '0;
    end else if (tag_valid[MULT_DELAY-1]) begin
      bus.out_rsp_valid   <= NUM_REQ'(1) << tag_id[MULT_DELAY-1];
      bus.out_rsp_product <= bus.inp_mult_product;
    end else begin
      bus.out_rsp_valid   <= '0;
      bus.out_rsp_product <= '0;
    end
  end

  // FSM state register for the non-pipelined mode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // The counter spans the issue and multiplier latency; RESP is the cycle
  // in which the tag pipeline registers the product, so leaving RESP
  // reopens arbitration exactly MULT_DELAY+2 cycles after the grant.
  // In pipelined mode the FSM simply stays in IDLE.
  always_comb begin
    next_state = state;
    next_count = count;
    if (PIPELINED == 0) begin
      unique case (state)
        IDLE: begin
          if (grant_fire) begin
            next_state = BUSY;
            next_count = CNTW'(MULT_DELAY);
          end
        end
        BUSY: begin
          next_count = count - CNTW'(1);
          if (count == CNTW'(1)) begin
            next_state = RESP;
          end
        end
        RESP: begin
          next_state = IDLE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Busy covers the issue strobe, every tag stage and the FSM hold states.
  always_comb begin
    tags_busy = 1'b0;
    for (int k = 0; k < MULT_DELAY; k++) begin
      tags_busy = tags_busy | tag_valid[k];
    end
    bus.out_busy = tags_busy | bus.out_mult_valid | (state != IDLE);
  end

endmodule

// File: tb/tb_float_point_mult_arbiter.sv
// tb_float_point_mult_arbiter
// Directed bench for float_point_mult_arbiter. Two instances share the
// clock and reset: dut_p (PIPELINED=1) and dut_n (PIPELINED=0), both with
// NUM_REQ=4, MULT_DELAY=3 and 32-bit floats. Each has a small behavioural
// multiplier model returning products MULT_DELAY cycles after issue.
// Cycle-level convention: inputs are driven and registered outputs are
// sampled 1 time unit after a rising edge; combinational grants are
// sampled 1 time unit after the inputs are driven.
module tb_float_point_mult_arbiter;

  localparam int W          = 32;
  localparam int NUM_REQ    = 4;
  localparam int MULT_DELAY = 3;

  localparam logic [31:0] F_HALF = 32'h3F00_0000;
  localparam logic [31:0] F1     = 32'h3F80_0000;
  localparam logic [31:0] F2     = 32'h4000_0000;
  localparam logic [31:0] F3     = 32'h4040_0000;
  localparam logic [31:0] F4     = 32'h4080_0000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] prod_tab [8] = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000,
                                32'h3F00_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000};
  logic [3:0]  exp_oh;
  logic [31:0] exp_prod;

  float_point_mult_arbiter_if #(.W(W), .NUM_REQ(NUM_REQ)) bus_p ();
  float_point_mult_arbiter_if #(.W(W), .NUM_REQ(NUM_REQ)) bus_n ();

  float_point_mult_arbiter #(
    .EXP_LEN(8), .MANTISSA_LEN(23), .NUM_REQ(NUM_REQ),
    .MULT_DELAY(MULT_DELAY), .PIPELINED(1)
  ) dut_p (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_p)
  );

  float_point_mult_arbiter #(
    .EXP_LEN(8), .MANTISSA_LEN(23), .NUM_REQ(NUM_REQ),
    .MULT_DELAY(MULT_DELAY), .PIPELINED(0)
  ) dut_n (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_n)
  );

  always #5 clock = ~clock;

  // Simple normal-number FP multiply (truncating), enough for exact
  // products of small values.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {x[31] ^ y[31], 31'd0};
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {x[31] ^ y[31], e[7:0], m};
  endfunction

  // Multiplier models: garbage outside valid slots so mistimed sampling shows.
  logic [31:0] mpipe_p [MULT_DELAY];
  logic [31:0] mpipe_n [MULT_DELAY];

  always @(posedge clock) begin
    mpipe_p[0] <= bus_p.out_mult_valid ? fp_mul(bus_p.out_mult_a, bus_p.out_mult_b) : 32'hDEAD_BEEF;
    mpipe_n[0] <= bus_n.out_mult_valid ? fp_mul(bus_n.out_mult_a, bus_n.out_mult_b) : 32'hDEAD_BEEF;
    for (int k = 1; k < MULT_DELAY; k++) begin
      mpipe_p[k] <= mpipe_p[k-1];
      mpipe_n[k] <= mpipe_n[k-1];
    end
  end

  assign bus_p.inp_mult_product = mpipe_p[MULT_DELAY-1];
  assign bus_n.inp_mult_product = mpipe_n[MULT_DELAY-1];

  function automatic logic [127:0] pack4(input logic [31:0] r0, input logic [31:0] r1,
                                         input logic [31:0] r2, input logic [31:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic [127:0] a, input logic [127:0] b);
    bus_p.inp_req_valid = valid;
    bus_p.inp_req_a     = a;
    bus_p.inp_req_b     = b;
  endtask

  task automatic apply_stimulus_np(input logic [3:0] valid, input logic [127:0] a, input logic [127:0] b);
    bus_n.inp_req_valid = valid;
    bus_n.inp_req_a     = a;
    bus_n.inp_req_b     = b;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Holds reset for two edges and releases it; the caller continues in the
  // first cycle out of reset.
  task automatic do_reset();
    reset_n = 1'b0;
    apply_stimulus(4'b0000, 128'd0, 128'd0);
    apply_stimulus_np(4'b0000, 128'd0, 128'd0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    apply_stimulus(4'b0000, 128'd0, 128'd0);
    apply_stimulus_np(4'b0000, 128'd0, 128'd0);

    // Reset state, sampled while reset is still asserted.
    next_cycle();
    next_cycle();
    check_output("rst_grant",     32'(bus_p.out_req_grant),   32'h0);
    check_output("rst_mvalid",    32'(bus_p.out_mult_valid),  32'h0);
    check_output("rst_mult_a",    bus_p.out_mult_a,           32'h0);
    check_output("rst_rsp_valid", 32'(bus_p.out_rsp_valid),   32'h0);
    check_output("rst_rsp_prod",  bus_p.out_rsp_product,      32'h0);
    check_output("rst_busy",      32'(bus_p.out_busy),        32'h0);
    check_output("rst_np_mvalid", 32'(bus_n.out_mult_valid),  32'h0);
    check_output("rst_np_busy",   32'(bus_n.out_busy),        32'h0);
    reset_n = 1'b1;
    next_cycle();
    next_cycle();

    // Single request from requester 2: 2.0 * 3.0.
    apply_stimulus(4'b0100, pack4(32'd0, 32'd0, F2, 32'd0), pack4(32'd0, 32'd0, F3, 32'd0));
    #1;
    check_output("t1_grant", 32'(bus_p.out_req_grant), 32'h4);
    next_cycle();
    check_output("t1_mvalid", 32'(bus_p.out_mult_valid), 32'h1);
    check_output("t1_mult_a", bus_p.out_mult_a, F2);
    check_output("t1_mult_b", bus_p.out_mult_b, F3);
    check_output("t1_busy1",  32'(bus_p.out_busy), 32'h1);
    apply_stimulus(4'b0000, 128'd0, 128'd0);
    #1;
    check_output("t1_grant_off", 32'(bus_p.out_req_grant), 32'h0);
    next_cycle();
    check_output("t1_mvalid_off", 32'(bus_p.out_mult_valid), 32'h0);
    check_output("t1_busy2",      32'(bus_p.out_busy), 32'h1);
    next_cycle();
    check_output("t1_busy3",      32'(bus_p.out_busy), 32'h1);
    next_cycle();
    check_output("t1_busy4",      32'(bus_p.out_busy), 32'h1);
    check_output("t1_rsp_early",  32'(bus_p.out_rsp_valid), 32'h0);
    next_cycle();
    check_output("t1_rsp_valid",  32'(bus_p.out_rsp_valid), 32'h4);
    check_output("t1_rsp_prod",   bus_p.out_rsp_product, 32'h40C0_0000);
    check_output("t1_busy_done",  32'(bus_p.out_busy), 32'h0);
    next_cycle();
    check_output("t1_rsp_clear",  32'(bus_p.out_rsp_valid), 32'h0);
    check_output("t1_prod_clear", bus_p.out_rsp_product, 32'h0);

    // All four requesters loaded for 8 cycles from reset; each presents a
    // new operand B (0.5 instead of 2.0) once its first request is granted.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c > 0) next_cycle();
      check_output("t2_mvalid", 32'(bus_p.out_mult_valid), (c >= 1 && c <= 8) ? 32'h1 : 32'h0);
      if (c >= 5 && c <= 12) begin
        exp_oh   = 4'b0001 << ((c - 5) % 4);
        exp_prod = prod_tab[c-5];
      end else begin
        exp_oh   = 4'b0000;
        exp_prod = 32'h0;
      end
      check_output("t2_rsp_valid", 32'(bus_p.out_rsp_valid), 32'(exp_oh));
      check_output("t2_rsp_prod",  bus_p.out_rsp_product, exp_prod);
      if (c < 8) begin
        apply_stimulus(4'b1111, pack4(F1, F2, F3, F4),
                       pack4((c > 0) ? F_HALF : F2, (c > 1) ? F_HALF : F2,
                             (c > 2) ? F_HALF : F2, (c > 3) ? F_HALF : F2));
        #1;
        exp_oh = 4'b0001 << (c % 4);
        check_output("t2_grant", 32'(bus_p.out_req_grant), 32'(exp_oh));
      end else begin
        apply_stimulus(4'b0000, 128'd0, 128'd0);
      end
    end

    // Pointer wrap: pointer sits at 3 after the rotation above.
    next_cycle();
    apply_stimulus(4'b1010, 128'd0, 128'd0);
    #1;
    check_output("t4_wrap_first", 32'(bus_p.out_req_grant), 32'h2);
    next_cycle();
    apply_stimulus(4'b1000, 128'd0, 128'd0);
    #1;
    check_output("t4_wrap_second", 32'(bus_p.out_req_grant), 32'h8);

    // Grant gating: the favoured requester has valid low and is skipped.
    next_cycle();
    apply_stimulus(4'b0110, 128'd0, 128'd0);
    #1;
    check_output("t5_skip_req0", 32'(bus_p.out_req_grant), 32'h2);
    next_cycle();
    apply_stimulus(4'b1001, 128'd0, 128'd0);
    #1;
    check_output("t5_skip_req2", 32'(bus_p.out_req_grant), 32'h8);
    next_cycle();
    apply_stimulus(4'b0000, 128'd0, 128'd0);
    #1;
    check_output("t5_no_stray", 32'(bus_p.out_req_grant), 32'h0);
    for (int c = 0; c < 8; c++) next_cycle();

    // Reset two cycles after a grant discards in-flight work.
    apply_stimulus(4'b0100, pack4(32'd0, 32'd0, F2, 32'd0), pack4(32'd0, 32'd0, F3, 32'd0));
    #1;
    check_output("t6_grant", 32'(bus_p.out_req_grant), 32'h4);
    next_cycle();
    apply_stimulus(4'b0010, pack4(32'd0, F4, 32'd0, 32'd0), pack4(32'd0, F2, 32'd0, 32'd0));
    #1;
    check_output("t6_grant2", 32'(bus_p.out_req_grant), 32'h2);
    next_cycle();
    apply_stimulus(4'b0000, 128'd0, 128'd0);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_mvalid", 32'(bus_p.out_mult_valid), 32'h0);
    check_output("t6_rst_mult_a", bus_p.out_mult_a, 32'h0);
    check_output("t6_rst_mult_b", bus_p.out_mult_b, 32'h0);
    check_output("t6_rst_busy",   32'(bus_p.out_busy), 32'h0);
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      check_output("t6_no_rsp", 32'(bus_p.out_rsp_valid), 32'h0);
    end
    apply_stimulus(4'b1111, 128'd0, 128'd0);
    #1;
    check_output("t6_grant_req0", 32'(bus_p.out_req_grant), 32'h1);
    next_cycle();
    apply_stimulus(4'b0000, 128'd0, 128'd0);

    // Non-pipelined: requesters 0 (2.0*3.0) and 1 (4.0*2.0) together.
    next_cycle();
    apply_stimulus_np(4'b0011, pack4(F2, F4, 32'd0, 32'd0), pack4(F3, F2, 32'd0, 32'd0));
    #1;
    check_output("t3_grant0", 32'(bus_n.out_req_grant), 32'h1);
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      check_output("t3_mvalid", 32'(bus_n.out_mult_valid), (c == 1 || c == 6) ? 32'h1 : 32'h0);
      check_output("t3_busy",   32'(bus_n.out_busy), (c == 5 || c == 10) ? 32'h0 : 32'h1);
      check_output("t3_rsp_valid", 32'(bus_n.out_rsp_valid),
                   (c == 5) ? 32'h1 : ((c == 10) ? 32'h2 : 32'h0));
      check_output("t3_rsp_prod", bus_n.out_rsp_product,
                   (c == 5) ? 32'h40C0_0000 : ((c == 10) ? 32'h4100_0000 : 32'h0));
      if (c == 1) check_output("t3_mult_a0", bus_n.out_mult_a, F2);
      if (c == 6) check_output("t3_mult_a1", bus_n.out_mult_a, F4);
      if (c <= 5) apply_stimulus_np(4'b0010, pack4(32'd0, F4, 32'd0, 32'd0), pack4(32'd0, F2, 32'd0, 32'd0));
      else        apply_stimulus_np(4'b0000, 128'd0, 128'd0);
      #1;
      check_output("t3_grant", 32'(bus_n.out_req_grant), (c == 5) ? 32'h2 : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_point_mult_arbiter.md
Name: float_point_mult_arbiter

Overview:
- Shares one float_point_multiplier instance among NUM_REQ requesters using round-robin arbitration.
- Issues one operand pair per grant to the multiplier and tracks requester IDs through a tag pipeline matched to the multiplier latency.
- Returns each product to the requester that issued it.
- Supports a pipelined multiplier (one issue per cycle) and a non-pipelined one (single operation in flight).

Parameters:
- EXP_LEN, 8, exponent width.
- MANTISSA_LEN, 23, mantissa width. W = EXP_LEN+MANTISSA_LEN+1.
- NUM_REQ, 4, number of requesters (2..16). IDW = clog2(NUM_REQ).
- MULT_DELAY, 3, cycles from out_mult_valid high to inp_mult_product valid (>=1).
- PIPELINED, 1, 1: multiplier accepts a new operand every cycle; 0: one operation in flight at a time.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- inp_req_valid  in  NUM_REQ  per-requester request.
- inp_req_a  in  NUM_REQ*W  packed operand A; requester i occupies [i*W +: W].
- inp_req_b  in  NUM_REQ*W  packed operand B, same packing.
- out_req_grant  out  NUM_REQ  one-hot, combinational; operands of the granted requester are taken at this clock edge.
- out_mult_a  out  W  registered operand A to the multiplier.
- out_mult_b  out  W  registered operand B to the multiplier.
- out_mult_valid  out  1  registered issue strobe.
- inp_mult_product  in  W  multiplier result, valid MULT_DELAY cycles after issue.
- out_rsp_valid  out  NUM_REQ  one-hot, registered, one-cycle result strobe.
- out_rsp_product  out  W  registered product; zero when no response is valid.
- out_busy  out  1  high while any operation is in flight.

Behaviour:
- Reset (async assert, sync release): all registered outputs 0, tag pipeline cleared, RR pointer = NUM_REQ-1 (requester 0 has highest priority first), FSM in IDLE. In-flight operations are discarded and produce no response.
- Arbitration: when a grant is allowed, the winner is the first set bit of inp_req_valid searching from pointer+1 with modulo wrap.
  - out_req_grant is combinational from inp_req_valid and state; it is never asserted for a requester with valid low.
  - The pointer updates to the winner only on a grant.
- Handshake: the requester holds valid and operands stable until it sees grant in the same cycle. After grant it may drop valid or present a new operand pair.
- Issue timing: for a grant in cycle t:
  - out_mult_a/b and out_mult_valid=1 are registered at cycle t+1.
  - out_mult_valid returns to 0 the following cycle unless a new grant was made.
- Tag pipeline: MULT_DELAY-deep shift register of {valid, id}.
  - Entry is loaded alongside out_mult_valid.
  - At depth MULT_DELAY, inp_mult_product is registered to out_rsp_product and out_rsp_valid[id] is set.
  - Response appears in cycle t+MULT_DELAY+2. No response backpressure: requesters must accept a strobe when it arrives.
- PIPELINED=1: grant allowed every cycle. Fully loaded requesters receive grants in rotating order 0,1,2,3,0,... with no idle cycles.
- PIPELINED=0, FSM states:
  - IDLE: grant allowed; on grant go to BUSY with counter=MULT_DELAY.
  - BUSY: no grant; counter decrements each cycle; at 0 go to RESP.
  - RESP: response registered, no grant; go to IDLE.
  - Result: next grant is no earlier than cycle t+MULT_DELAY+2.
- out_busy: OR of tag-pipeline valid bits and out_mult_valid; in PIPELINED=0 it is also high in BUSY/RESP.
- Simultaneous requests: exactly one grant per cycle. If a requester's valid drops in the same cycle it would have won, the search passes it over.
- Arithmetic: products are passed through unchanged; the block does no FP processing.

Test Plan:
- Single request: NUM_REQ=4, MULT_DELAY=3, PIPELINED=1. Req 2 presents a=0x40000000, b=0x40400000 in cycle 5 -> grant[2] in cycle 5; out_mult_valid in cycle 6; out_rsp_valid=4'b0100 with product 0x40C00000 in cycle 10. out_busy is high in cycles 6-9.
- All four requesters held valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3. Responses come in the same order, each with its own product, back-to-back, no gaps.
- PIPELINED=0, reqs 0 and 1 valid together -> grant[0] at t, grant[1] at t+5. Responses at t+5 and t+10. No out_mult_valid while BUSY.
- Pointer wrap: pointer=3, requesters 1 and 3 valid -> grant[1], then grant[3].
- Reset asserted 2 cycles after a grant -> all outputs 0 immediately. No response appears after release. The next grant goes to requester 0 when all requesters are valid.
- Grant gating: a requester drops valid in the cycle the pointer favours it -> the next valid requester is granted instead. No stray grant bit is asserted.
